// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer slice.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        DONE    = 2'd2
    } state_e;

    localparam logic [1:0] CAUSE_EXT = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;

endpackage

// File: rtl/reset_sync_chain.sv
// Async-assert / sync-deassert reset synchroniser.
module reset_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rstn_unsync_i,
    output logic srst_n
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rstn_unsync_i) begin
        if (!rstn_unsync_i) sync_q <= '0;
        else                sync_q <= {sync_q[STAGES-2:0], 1'b1};
    end

    assign srst_n = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Synchronises the external reset, then releases NUM_CH resets in ascending
// order after a minimum hold time; also handles a software reset request.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_CH      = 4,
    parameter int MIN_ASSERT  = 16,
    parameter int GAP_CYCLES  = 8
) (
    input  logic              clk_i,
    input  logic              rstn_unsync_i,
    input  logic              sw_rst_req_i,
    output logic [NUM_CH-1:0] rstn_o,
    output logic              rst_done_o,
    output logic [1:0]        rst_cause_o
);

    localparam int MAXC = (MIN_ASSERT > GAP_CYCLES) ? MIN_ASSERT : GAP_CYCLES;
    localparam int CNTW = $clog2(MAXC + 1);
    localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNTW-1:0]   MIN_LAST = CNTW'(MIN_ASSERT - 1);
    localparam logic [CNTW-1:0]   GAP_LAST = CNTW'(GAP_CYCLES - 1);
    localparam logic [CHW-1:0]    CH_LAST  = CHW'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] CH_ONE   = NUM_CH'(1);

    logic srst_n;

    reset_sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_i         (clk_i),
        .rstn_unsync_i (rstn_unsync_i),
        .srst_n        (srst_n)
    );

    state_e            state_q, state_n;
    logic [CNTW-1:0]   cnt_q, cnt_n;
    logic [CHW-1:0]    ch_q, ch_n, ch_inc;
    logic [NUM_CH-1:0] rstn_q, rstn_n;
    logic              done_q, done_n;
    logic [1:0]        cause_q, cause_n;

    always_ff @(posedge clk_i or negedge rstn_unsync_i) begin
        if (!rstn_unsync_i) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            ch_q    <= '0;
            rstn_q  <= '0;
            done_q  <= 1'b0;
            cause_q <= CAUSE_EXT;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            ch_q    <= ch_n;
            rstn_q  <= rstn_n;
            done_q  <= done_n;
            cause_q <= cause_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        ch_n    = ch_q;
        rstn_n  = rstn_q;
        done_n  = done_q;
        cause_n = cause_q;
        ch_inc  = ch_q + CHW'(1);
        if (srst_n) begin
            // A software request overrides any release due on the same edge.
            if (sw_rst_req_i) begin
                state_n = HOLD;
                cnt_n   = '0;
                ch_n    = '0;
                rstn_n  = '0;
                done_n  = 1'b0;
                cause_n = CAUSE_SW;
            end else begin
                case (state_q)
                    HOLD: begin
                        if (cnt_q == MIN_LAST) begin
                            cnt_n     = '0;
                            ch_n      = '0;
                            rstn_n[0] = 1'b1;
                            if (NUM_CH == 1) begin
                                done_n  = 1'b1;
                                state_n = DONE;
                            end else begin
                                state_n = RELEASE;
                            end
                        end else begin
                            cnt_n = cnt_q + CNTW'(1);
                        end
                    end
                    RELEASE: begin
                        if (cnt_q == GAP_LAST) begin
                            cnt_n  = '0;
                            ch_n   = ch_inc;
                            rstn_n = rstn_q | (CH_ONE << ch_inc);
                            if (ch_inc == CH_LAST) begin
                                done_n  = 1'b1;
                                state_n = DONE;
                            end
                        end else begin
                            cnt_n = cnt_q + CNTW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rstn_o      = rstn_q;
    assign rst_done_o  = done_q;
    assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default instance plus a minimal-parameter
// instance, both checked every edge against release-time arithmetic.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rstn_unsync = 1'b0;
    logic       sw_req = 1'b0;
    logic [3:0] rstn0;
    logic       done0;
    logic [1:0] cause0;
    logic [0:0] rstn1;
    logic       done1;
    logic [1:0] cause1;

    always #5 clk = ~clk;

    reset_sequencer u_dut0 (
        .clk_i         (clk),
        .rstn_unsync_i (rstn_unsync),
        .sw_rst_req_i  (sw_req),
        .rstn_o        (rstn0),
        .rst_done_o    (done0),
        .rst_cause_o   (cause0)
    );

    reset_sequencer #(
        .SYNC_STAGES (3),
        .NUM_CH      (1),
        .MIN_ASSERT  (1),
        .GAP_CYCLES  (1)
    ) u_dut1 (
        .clk_i         (clk),
        .rstn_unsync_i (rstn_unsync),
        .sw_rst_req_i  (sw_req),
        .rstn_o        (rstn1),
        .rst_done_o    (done1),
        .rst_cause_o   (cause1)
    );

    localparam longint FAR = 64'd1 << 40;

    int     p_s [2] = '{2, 3};
    int     p_n [2] = '{4, 1};
    int     p_m [2] = '{16, 1};
    int     p_g [2] = '{8, 1};
    longint start [2];
    logic [1:0] cause_m [2];
    longint n = 0;
    longint e1 = 0;
    longint base = 0;
    bit     rst_low = 1'b1;
    int     total = 0;
    int     passed = 0;
    int     failed = 0;

    // Bit i of instance d is high once edge n reaches start + i*gap.
    function automatic logic [3:0] exp_rstn(int d);
        logic [3:0] r = '0;
        for (int i = 0; i < p_n[d]; i++)
            r[i] = !rst_low && (n >= start[d] + longint'(i * p_g[d]));
        return r;
    endfunction

    function automatic logic exp_done(int d);
        return !rst_low && (n >= start[d] + longint'((p_n[d] - 1) * p_g[d]));
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h at edge %0d", tag, obs, exp, n);
        end
    endtask

    task automatic check_all();
        logic [3:0] e0, e1v;
        e0  = exp_rstn(0);
        e1v = exp_rstn(1);
        chk("d0_rstn",  {4'b0, rstn0},  {4'b0, e0});
        chk("d0_done",  {7'b0, done0},  {7'b0, exp_done(0)});
        chk("d0_cause", {6'b0, cause0}, {6'b0, cause_m[0]});
        chk("d1_rstn",  {7'b0, rstn1},  {7'b0, e1v[0]});
        chk("d1_done",  {7'b0, done1},  {7'b0, exp_done(1)});
        chk("d1_cause", {6'b0, cause1}, {6'b0, cause_m[1]});
    endtask

    task automatic tick(input logic v);
        sw_req = v;
        @(posedge clk);
        n++;
        for (int d = 0; d < 2; d++) begin
            if (v && !rst_low && n >= e1 + p_s[d]) begin
                start[d]   = n + p_m[d];
                cause_m[d] = 2'b10;
            end
        end
        #1 check_all();
    endtask

    task automatic run_to(input longint t);
        while (n < t) tick(1'b0);
    endtask

    task automatic release_rst();
        #1 rstn_unsync = 1'b1;
        rst_low = 1'b0;
        e1 = n + 1;
        for (int d = 0; d < 2; d++) start[d] = e1 - 1 + p_s[d] + p_m[d];
    endtask

    task automatic drop_rst();
        #2 rstn_unsync = 1'b0;
        rst_low = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start[d]   = FAR;
            cause_m[d] = 2'b01;
        end
        #1 check_all();
    endtask

    initial begin
        int r;
        for (int d = 0; d < 2; d++) begin
            start[d]   = FAR;
            cause_m[d] = 2'b01;
        end
        repeat (3) tick(1'b0);

        // Power-on, then async drop between relative edges 30 and 31.
        release_rst();
        base = e1 - 1;
        run_to(base + 30);
        drop_rst();
        repeat (3) tick(1'b0);

        // Full sequence, single software pulse at edge 100, held request 200..209.
        release_rst();
        base = e1 - 1;
        run_to(base + 99);
        tick(1'b1);
        run_to(base + 150);
        run_to(base + 199);
        repeat (10) tick(1'b1);
        run_to(base + 260);

        // Software request colliding with the bit-1 release at edge 26.
        drop_rst();
        repeat (2) tick(1'b0);
        release_rst();
        base = e1 - 1;
        run_to(base + 25);
        tick(1'b1);
        run_to(base + 60);

        // Random requests and async resets.
        for (int k = 0; k < 600; k++) begin
            r = int'($urandom_range(0, 99));
            if (rst_low) begin
                if (r < 30) release_rst();
                tick(1'b0);
            end else if (r < 2) begin
                drop_rst();
            end else begin
                tick(r < 8);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised reset controller: synchronises one asynchronous active-low reset into `clk_i` with a configurable synchroniser depth. It then releases `NUM_CH` downstream reset outputs in fixed ascending order, spacing each release by a programmable gap, after enforcing a minimum assertion time. It also accepts a synchronous software reset request and reports the cause of the last reset. It sits at the top of each clock domain, feeding per-subsystem resets (e.g. bus fabric, then peripherals, then cores).

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser flops on the deassertion path; legal range ≥2.
- `NUM_CH`, default 4: number of sequenced reset outputs; legal range ≥1.
- `MIN_ASSERT`, default 16: cycles all outputs stay low after the reset source deasserts; legal range ≥1.
- `GAP_CYCLES`, default 8: cycles between consecutive channel releases; legal range ≥1.

Ports:
- `clk_i` in 1: clock.
- `rstn_unsync_i` in 1: reset, asynchronous, active-low.
- `sw_rst_req_i` in 1: synchronous software reset request, active-high, level-sampled each edge.
- `rstn_o` out `NUM_CH`: sequenced active-low resets. Bit 0 releases first.
- `rst_done_o` out 1: high once all channels are released.
- `rst_cause_o` out 2: cause of the last reset. 2'b01 = external, 2'b10 = software.

## Operation
- Reset values while `rstn_unsync_i`=0:
  - `rstn_o` = all 0, `rst_done_o`=0, `rst_cause_o`=2'b01.
  - FSM = HOLD, counter = 0, synchroniser = all 0.
  - Assertion is asynchronous and immediate.
  - Every output flop has an async clear on `rstn_unsync_i`. All outputs come directly from flops, with no combinational glitches.
- Deassertion path: `rstn_unsync_i` passes through a `SYNC_STAGES`-deep chain to produce `srst_n`. The FSM advances only when `srst_n`=1.
- FSM states: HOLD, RELEASE, DONE.
  - HOLD: all `rstn_o`=0. The counter counts `MIN_ASSERT` cycles, then bit 0 is set and the FSM enters RELEASE with counter cleared.
  - RELEASE: the counter counts `GAP_CYCLES` cycles, then the next bit is set. When bit `NUM_CH-1` is set, `rst_done_o` is set in the same cycle and the FSM enters DONE.
  - With `NUM_CH`=1 the FSM goes HOLD→DONE directly, setting bit 0 and `rst_done_o` together.
  - DONE: holds all outputs.
- Software request: `sw_rst_req_i`=1 sampled in any state (with `srst_n`=1) has the following effect at that edge:
  - `rstn_o` = all 0, `rst_done_o`=0, `rst_cause_o`=2'b10.
  - FSM enters HOLD with counter = 0.
  - While the request is held high, the FSM remains in HOLD and the counter restarts every edge. The release sequence starts counting from the last edge on which the request was sampled high.
  - `sw_rst_req_i` is ignored while `srst_n`=0.
- `rst_cause_o` changes only on external reset assertion (→01) or on an accepted software request (→10).
- Counter width is `$clog2(max(MIN_ASSERT, GAP_CYCLES)+1)`. The counter never wraps, because it is cleared on every state or channel step.
- Released channels stay high until the next reset event. The sequence is monotonic with no re-assertion of individual bits.

## Timing
Edge 1 is the first rising edge at which `rstn_unsync_i`=1 meets setup.
- `srst_n` rises at edge `SYNC_STAGES`.
- `rstn_o[i]` rises at edge `SYNC_STAGES + MIN_ASSERT + i*GAP_CYCLES`.
- `rst_done_o` rises together with `rstn_o[NUM_CH-1]`.
- With defaults: `rstn_o[0..3]` rise at edges 18/26/34/42, and `rst_done_o` at 42.
- Software request last sampled high at edge k: `rstn_o` is 0 after edge k, and `rstn_o[i]` rises at edge `k + MIN_ASSERT + i*GAP_CYCLES`.
- Async assert mid-sequence (any state): all outputs go low with no clock needed, and the full sequence restarts from edge 1 after release.
- Simultaneous software request and channel-release edge: the request wins, and that channel stays low.

## Structure
- Package `reset_seq_pkg` holds:
  - the FSM state enum (HOLD, RELEASE, DONE);
  - cause constants `CAUSE_EXT`=2'b01 and `CAUSE_SW`=2'b10.
- Sub-module `reset_sync_chain #(STAGES)` implements the async-assert / synchronous-deassert flop chain producing `srst_n`. It is instantiated once.
- The FSM, counter, channel index, and output registers live in the top module.

## Test plan
- Power-on, defaults: release `rstn_unsync_i` before edge 1 → `rstn_o` steps 0001/0011/0111/1111 at edges 18/26/34/42, `rst_done_o`=1 at 42, `rst_cause_o`=01.
- Async assert mid-RELEASE: drop `rstn_unsync_i` between edges 30 and 31 → `rstn_o`=0000 immediately with no clock edge. Re-release → the sequence repeats with edge offsets identical to the first test.
- Software pulse in DONE: 1-cycle `sw_rst_req_i` sampled at edge 100 → `rstn_o`=0000 after edge 100, bit 0 high at edge 116, all high at 140, `rst_cause_o`=10.
- Held software request: `sw_rst_req_i` high for edges 100–109 → `rstn_o` stays 0000; bit 0 rises at edge 125, all high at 149.
- Request collides with release: software request sampled at edge 26 during power-on → bit 1 is not released, the sequence restarts with bit 0 high at edge 42, and `rst_cause_o`=10.
- Parameter sweep: `SYNC_STAGES`=3, `NUM_CH`=1, `MIN_ASSERT`=1, `GAP_CYCLES`=1 → `rstn_o[0]` and `rst_done_o` rise together at edge 4.
